// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared FSM state type and default geometry/phase constants for Bennett-phased SRAM control
package sram_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_ADDR, WAIT_DATA, WAIT_EN_ON, WAIT_EN_OFF, RESP} state_t;
  localparam int DEF_PHASES    = 10;
  localparam int DEF_ADDR_W    = 5;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_PH   = 2;
  localparam int DEF_DATA_PH   = 4;
  localparam int DEF_RD_ON_PH  = 6;
  localparam int DEF_RD_OFF_PH = 8;
  localparam int DEF_WR_ON_PH  = 8;
  localparam int DEF_WR_OFF_PH = 9;
  localparam int DEF_SRCLK_PH  = 6;
endpackage

// File: rtl/bennett_phase_edge.sv
// bennett_phase_edge: rising-edge detector for the Bennett phase vector in the clk domain
// Ports: clk, reset (sync, active-high), clkpos (phase vector in), rise (one-clk pulse per phase rise)
module bennett_phase_edge #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] clkpos,
  output logic [N-1:0] rise
);
  logic [N-1:0] clkpos_q;
  always_ff @(posedge clk)
    clkpos_q <= reset ? '0 : clkpos;
  assign rise = clkpos & ~clkpos_q;
endmodule

// File: rtl/sram_bank_ctrl.sv
// sram_bank_ctrl: single-outstanding request initiator that sequences sram_2port_bank accesses onto Bennett phases
// Ports: clk/reset; clkpos/Mclk from bennett_clock; req_* valid/ready request in; rsp_* completion out;
//        Addr_A/Addr_B/in_data/ReadEn/WriteEn/RegWrtBar/srclkneg/srclkpos to the bank; outA/outB from the bank
module sram_bank_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int PHASES    = DEF_PHASES,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_PH   = DEF_ADDR_PH,
  parameter int DATA_PH   = DEF_DATA_PH,
  parameter int RD_ON_PH  = DEF_RD_ON_PH,
  parameter int RD_OFF_PH = DEF_RD_OFF_PH,
  parameter int WR_ON_PH  = DEF_WR_ON_PH,
  parameter int WR_OFF_PH = DEF_WR_OFF_PH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PHASES-1:0] clkpos,
  input  logic              Mclk,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr_a,
  input  logic [ADDR_W-1:0] req_addr_b,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_data_a,
  output logic [DATA_W-1:0] rsp_data_b,
  output logic [ADDR_W-1:0] Addr_A,
  output logic [ADDR_W-1:0] Addr_B,
  output logic              ReadEn,
  output logic              WriteEn,
  output logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] outA,
  input  logic [DATA_W-1:0] outB,
  output logic              RegWrtBar,
  output logic              srclkneg,
  output logic              srclkpos
);
  logic [PHASES-1:0] rise;
  state_t            state;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_a, lat_b;
  logic [DATA_W-1:0] lat_d;

  bennett_phase_edge #(.N(PHASES)) u_edge (
    .clk    (clk),
    .reset  (reset),
    .clkpos (clkpos),
    .rise   (rise)
  );

  assign RegWrtBar = ~clkpos[RD_ON_PH];
  assign srclkneg  = (Mclk ^ clkpos[DEF_SRCLK_PH]) & clkpos[DEF_SRCLK_PH];
  assign srclkpos  = ~srclkneg;

  // Acceptance happens in IDLE, so a rise[ADDR_PH] coinciding with acceptance is
  // never seen by WAIT_ADDR and the access starts on the next Bennett cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_we     <= 1'b0;
      rsp_data_a <= '0;
      rsp_data_b <= '0;
      Addr_A     <= '0;
      Addr_B     <= '0;
      in_data    <= '0;
      ReadEn     <= 1'b0;
      WriteEn    <= 1'b0;
      lat_we     <= 1'b0;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_d      <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          lat_we    <= req_we;
          lat_a     <= req_addr_a;
          lat_b     <= req_addr_b;
          lat_d     <= req_wdata;
          req_ready <= 1'b0;
          state     <= WAIT_ADDR;
        end
        WAIT_ADDR: if (rise[ADDR_PH]) begin
          Addr_A <= lat_a;
          Addr_B <= lat_b;
          state  <= WAIT_DATA;
        end
        WAIT_DATA: if (rise[DATA_PH]) begin
          if (lat_we) in_data <= lat_d;
          state <= WAIT_EN_ON;
        end
        WAIT_EN_ON: if (rise[lat_we ? WR_ON_PH : RD_ON_PH]) begin
          ReadEn  <= ~lat_we;
          WriteEn <= lat_we;
          state   <= WAIT_EN_OFF;
        end
        WAIT_EN_OFF: if (rise[lat_we ? WR_OFF_PH : RD_OFF_PH]) begin
          ReadEn    <= 1'b0;
          WriteEn   <= 1'b0;
          if (!lat_we) begin
            rsp_data_a <= outA;
            rsp_data_b <= outB;
          end
          rsp_we    <= lat_we;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sram_bank_ctrl.md
Name: sram_bank_ctrl

Overview:
- Synthesizable initiator for the sram_2port_bank.
- Accepts one read or write request at a time on a valid/ready interface.
- Sequences Addr_A/Addr_B, input data, ReadEn, WriteEn, RegWrtBar and srclk onto the Bennett clock phases produced by bennett_clock (PHASES=10).
- Captures outA/outB and returns them on a response interface.
- Sits between the pipeline's register-access stage and the adiabatic SRAM bank.

Parameters:
- PHASES, 10, number of Bennett phases in clkpos
- ADDR_W, 5, register address width
- DATA_W, 16, data width
- ADDR_PH, 2, phase whose rising edge launches the addresses
- DATA_PH, 4, phase whose rising edge launches write data
- RD_ON_PH, 6, phase rise that asserts ReadEn
- RD_OFF_PH, 8, phase rise that deasserts ReadEn and captures read data
- WR_ON_PH, 8, phase rise that asserts WriteEn
- WR_OFF_PH, 9, phase rise that deasserts WriteEn

Ports:
- clk  in  1  system clock; also drives bennett_clock
- reset  in  1  synchronous, active-high reset
- clkpos  in  PHASES  Bennett phase vector from bennett_clock
- Mclk  in  1  Bennett master clock
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr_a  in  ADDR_W  port A address (write target / read A)
- req_addr_b  in  ADDR_W  port B address (read B)
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_we  out  1  echo of req_we for this completion
- rsp_data_a  out  DATA_W  captured outA (reads only)
- rsp_data_b  out  DATA_W  captured outB (reads only)
- Addr_A  out  ADDR_W  to bank
- Addr_B  out  ADDR_W  to bank
- ReadEn  out  1  to bank
- WriteEn  out  1  to bank
- in_data  out  DATA_W  to bank `in`
- outA  in  DATA_W  from bank
- outB  in  DATA_W  from bank
- RegWrtBar  out  1  to bank; equals ~clkpos[RD_ON_PH], combinational
- srclkneg  out  1  (Mclk ^ clkpos[6]) & clkpos[6], combinational
- srclkpos  out  1  ~srclkneg

Behaviour:
- Phase edges are detected in the clk domain: rise[i] = clkpos[i] & ~clkpos_q[i], where clkpos_q is clkpos registered and reset to 0.
- FSM states: IDLE, WAIT_ADDR, WAIT_DATA, WAIT_EN_ON, WAIT_EN_OFF, RESP.
  - IDLE: req_ready=1. On req_valid, latch req_* and go to WAIT_ADDR.
  - WAIT_ADDR: on rise[ADDR_PH], drive Addr_A/Addr_B from the latched request and go to WAIT_DATA. A rise[ADDR_PH] in the same cycle as acceptance is ignored; the transaction waits for the next Bennett cycle.
  - WAIT_DATA: on rise[DATA_PH], drive in_data (writes only; reads leave in_data unchanged) and go to WAIT_EN_ON.
  - WAIT_EN_ON:
    - read: on rise[RD_ON_PH], ReadEn=1.
    - write: on rise[WR_ON_PH], WriteEn=1.
    - Then go to WAIT_EN_OFF.
  - WAIT_EN_OFF:
    - read: on rise[RD_OFF_PH], ReadEn=0 and capture outA/outB into rsp_data_a/b.
    - write: on rise[WR_OFF_PH], WriteEn=0.
    - Then go to RESP.
  - RESP: rsp_valid=1 for exactly one clk, then IDLE.
- req_ready=1 only in IDLE, so at most one transaction is in flight. Back-to-back requests therefore complete at most one per Bennett cycle.
- Addr_A, Addr_B, in_data and rsp_data_* hold their last values between transactions.
- ReadEn and WriteEn are never asserted together.
- Reset values: Addr_A=0, Addr_B=0, in_data=0, ReadEn=0, WriteEn=0, rsp_valid=0, rsp_we=0, rsp_data_a=0, rsp_data_b=0, req_ready=1 in the cycle after reset deasserts, FSM=IDLE.
- Reset mid-transaction: the transaction is dropped with no rsp_valid, and enables are deasserted on the next clk edge.
- Read latency: from acceptance to rsp_valid is the time to the next rise[ADDR_PH] plus the time to rise[RD_OFF_PH] plus 1 clk.
- Write latency: the same, ending at rise[WR_OFF_PH] plus 1 clk.

Decomposition:
- Package sram_ctrl_pkg holds:
  - state_t enum
  - default phase index constants
  - ADDR_W/DATA_W defaults
- Sub-module bennett_phase_edge: registers clkpos and outputs the rise vector. Reused by other Bennett-phased controllers.

Test Plan:
- Write: req_we=1, addr_a=5'h01, wdata=16'hAAAA.
  - Addr_A=1 after rise[2]; in_data=AAAA after rise[4].
  - WriteEn high from rise[8] to rise[9].
  - rsp_valid pulse with rsp_we=1.
- Read-after-write: read with addr_a=1, addr_b=0 against a bank model.
  - ReadEn high from rise[6] to rise[8].
  - rsp_data_a=16'hAAAA; WriteEn stays 0.
- Unwritten read: read addr_a=5'h03 -> rsp_data_a equals the model's reset content (0). Addr_A=3 after rise[2].
- Acceptance edge case: req_valid asserted the same cycle as rise[2] -> no address change that cycle; addresses update on the following Bennett cycle's rise[2].
- Back-to-back: two queued reads -> req_ready low during the first; the second completes exactly one Bennett period later; rsp_valid is a single-cycle pulse each time.
- Reset mid-write: reset asserted after rise[8] with WriteEn=1 -> WriteEn=0 next clk; no rsp_valid; all outputs at reset values; next request proceeds normally.
